// File: rtl/tx_keying_ctrl.sv
// tx_keying_ctrl: TX mixer phase accumulator, tuning handshake and PTT amplitude-ramp keying.
module tx_keying_ctrl #(
  parameter int RAMP_LOG2 = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        freq_data,
  input  logic               freq_valid,
  output logic               freq_ready,
  input  logic               phase_clr,
  input  logic               ptt,
  input  logic signed [17:0] in_i,
  input  logic signed [17:0] in_q,
  output logic [31:0]        phi,
  output logic signed [17:0] out_i,
  output logic signed [17:0] out_q,
  output logic               tx_active
);
  localparam int GW = RAMP_LOG2 + 1;
  localparam int PW = GW + 19;
  localparam logic [GW-1:0] FULL = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic [GW-1:0] ONE = {{RAMP_LOG2{1'b0}}, 1'b1};
  typedef enum logic [1:0] {IDLE, RAMP_UP, ON, RAMP_DOWN} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] g_q, g_d, g1_q, g1_d, g_up, g_dn;
  logic [31:0] freq_q, freq_d, phi_q, phi_d;
  logic signed [17:0] i1_q, i1_d, q1_q, q1_d, oi_q, oi_d, oq_q, oq_d;
  logic signed [PW-1:0] prod_i, prod_q;
  always_comb begin
    state_d = state_q;
    g_d = g_q;
    g_up = g_q + ONE;
    g_dn = g_q - ONE;
    unique case (state_q)
      IDLE: begin
        state_d = ptt ? RAMP_UP : IDLE;
        g_d = ptt ? ONE : '0;
      end
      RAMP_UP: begin
        state_d = !ptt ? (g_dn == '0 ? IDLE : RAMP_DOWN) : (g_up == FULL ? ON : RAMP_UP);
        g_d = ptt ? g_up : g_dn;
      end
      ON: begin
        state_d = ptt ? ON : RAMP_DOWN;
        g_d = ptt ? FULL : FULL - ONE;
      end
      RAMP_DOWN: begin
        state_d = ptt ? (g_up == FULL ? ON : RAMP_UP) : (g_dn == '0 ? IDLE : RAMP_DOWN);
        g_d = ptt ? g_up : g_dn;
      end
    endcase
    freq_ready = (state_q == IDLE) || (state_q == ON);
    freq_d = (freq_valid && freq_ready) ? freq_data : freq_q;
    phi_d = phase_clr ? '0 : phi_q + freq_q;
    i1_d = in_i;
    q1_d = in_q;
    g1_d = g_q;
    prod_i = PW'(i1_q) * PW'($signed({1'b0, g1_q}));
    prod_q = PW'(q1_q) * PW'($signed({1'b0, g1_q}));
    oi_d = 18'(prod_i >>> RAMP_LOG2);
    oq_d = 18'(prod_q >>> RAMP_LOG2);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      g_q <= '0;
      g1_q <= '0;
      freq_q <= '0;
      phi_q <= '0;
      i1_q <= '0;
      q1_q <= '0;
      oi_q <= '0;
      oq_q <= '0;
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      g1_q <= g1_d;
      freq_q <= freq_d;
      phi_q <= phi_d;
      i1_q <= i1_d;
      q1_q <= q1_d;
      oi_q <= oi_d;
      oq_q <= oq_d;
    end
  end
  assign phi = phi_q;
  assign out_i = oi_q;
  assign out_q = oq_q;
  assign tx_active = state_q != IDLE;
endmodule

// File: tb/tb_tx_keying_ctrl.sv
// tb_tx_keying_ctrl: directed test-plan steps plus random keying/tuning against a gain-level reference model.
module tb_tx_keying_ctrl;
  localparam int RL = 2;
  localparam int FULL = 1 << RL;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] freq_data = '0;
  logic freq_valid = 1'b0;
  logic freq_ready;
  logic phase_clr = 1'b0;
  logic ptt = 1'b0;
  logic signed [17:0] in_i = '0;
  logic signed [17:0] in_q = '0;
  logic [31:0] phi;
  logic signed [17:0] out_i, out_q;
  logic tx_active;
  int checks = 0;
  int errors = 0;
  int m_g, s_i, s_q, s_g, m_oi, m_oq;
  logic [31:0] m_phi, m_freq;
  tx_keying_ctrl #(.RAMP_LOG2(RL)) dut (
    .clk(clk), .rst(rst), .freq_data(freq_data), .freq_valid(freq_valid),
    .freq_ready(freq_ready), .phase_clr(phase_clr), .ptt(ptt), .in_i(in_i),
    .in_q(in_q), .phi(phi), .out_i(out_i), .out_q(out_q), .tx_active(tx_active)
  );
  always #5 clk = ~clk;
  function automatic int scale(int x, int g);
    longint p;
    p = longint'(x) * longint'(g);
    return p >= 0 ? int'(p / FULL) : -int'((-p + FULL - 1) / FULL);
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("phi", phi, m_phi);
    chk("out_i", 32'(out_i), m_oi);
    chk("out_q", 32'(out_q), m_oq);
    chk("tx_active", {31'b0, tx_active}, {31'b0, m_g != 0});
    chk("freq_ready", {31'b0, freq_ready}, {31'b0, (m_g == 0) || (m_g == FULL)});
  endtask
  task automatic step();
    bit acc;
    int ng;
    acc = freq_valid && ((m_g == 0) || (m_g == FULL));
    ng = ptt ? ((m_g + 1 > FULL) ? FULL : m_g + 1) : ((m_g == 0) ? 0 : m_g - 1);
    @(posedge clk);
    m_oi = scale(s_i, s_g);
    m_oq = scale(s_q, s_g);
    s_i = int'(in_i);
    s_q = int'(in_q);
    s_g = m_g;
    m_g = ng;
    m_phi = phase_clr ? 32'd0 : m_phi + m_freq;
    if (acc) m_freq = freq_data;
    #1 check_all();
    if (acc) freq_valid = 1'b0;
  endtask
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    m_g = 0; s_i = 0; s_q = 0; s_g = 0; m_oi = 0; m_oq = 0;
    m_phi = '0; m_freq = '0;
    check_all();
    #2 rst = 1'b1;
  endtask
  initial begin
    logic [31:0] p;
    @(posedge clk);
    #1 do_reset();
    freq_data = 32'h1000_0000;
    freq_valid = 1'b1;
    step();
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("t1_phi", phi, 32'(k) << 28);
    end
    do_reset();
    in_i = 18'sd1000;
    in_q = -18'sd1000;
    ptt = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k >= 3) chk("t2_out_i", 32'(out_i), 32'((k - 2) * 250));
      if (k >= 3) chk("t2_out_q", 32'(out_q), 32'(-(k - 2) * 250));
      if (k == 3 || k == 4) chk("t2_on", {31'b0, freq_ready}, {31'b0, k == 4});
    end
    do_reset();
    step();
    step();
    ptt = 1'b0;
    step();
    chk("t3_active_g1", {31'b0, tx_active}, 32'd1);
    step();
    chk("t3_idle_g0", {31'b0, tx_active}, 32'd0);
    do_reset();
    ptt = 1'b1;
    step();
    freq_data = 32'h1234;
    freq_valid = 1'b1;
    step();
    chk("t4_stall", {31'b0, freq_ready}, 32'd0);
    step();
    step();
    chk("t4_on_ready", {31'b0, freq_ready}, 32'd1);
    step();
    chk("t4_valid_dropped", {31'b0, freq_valid}, 32'd0);
    p = phi;
    step();
    chk("t4_phi_step", phi, p + 32'h1234);
    ptt = 1'b0;
    do_reset();
    freq_data = 32'd5;
    freq_valid = 1'b1;
    repeat (4) step();
    phase_clr = 1'b1;
    step();
    chk("t5_clr", phi, 32'd0);
    phase_clr = 1'b0;
    step();
    chk("t5_phi5", phi, 32'd5);
    step();
    chk("t5_phi10", phi, 32'd10);
    do_reset();
    in_i = 18'sd1000;
    ptt = 1'b1;
    repeat (8) step();
    chk("t6_pre_out_i", 32'(out_i), 32'd1000);
    do_reset();
    chk("t6_rst_out_i", 32'(out_i), 32'd0);
    step();
    chk("t6_restart", {31'b0, tx_active}, 32'd1);
    repeat (400) begin
      if ($urandom_range(5) == 0) ptt = ~ptt;
      in_i = 18'($urandom);
      in_q = 18'($urandom);
      phase_clr = $urandom_range(15) == 0;
      if (!freq_valid && $urandom_range(7) == 0) begin
        freq_valid = 1'b1;
        freq_data = $urandom;
      end
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tx_keying_ctrl.md
# tx_keying_ctrl

Transmit-path controller that sequences the TX upconversion mixer. It owns the 32-bit phase accumulator that drives the mixer's `phi` input and accepts tuning-word updates through a valid/ready handshake. It also runs the PTT keying state machine, which applies a linear amplitude ramp to the baseband I/Q before that I/Q reaches the mixer's `i_sig`/`q_sig` inputs. It sits between the TX baseband source and the mixer, in the same clock domain.

## Interface

**Parameters**
- `RAMP_LOG2`, default 8: ramp length is 2^RAMP_LOG2 cycles. Legal range 1..12.

**Ports**
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `freq_data`  in  32  phase increment (tuning word), unsigned.
- `freq_valid`  in  1  `freq_data` is valid.
- `freq_ready`  out  1  controller can accept a tuning word.
- `phase_clr`  in  1  synchronous clear of the phase accumulator.
- `ptt`  in  1  keying request, level sensitive.
- `in_i`, `in_q`  in  18 signed  baseband I/Q from the upstream source.
- `phi`  out  32  accumulated phase, to the mixer `phi`.
- `out_i`, `out_q`  out  18 signed  ramp-scaled I/Q, to the mixer `i_sig`/`q_sig`.
- `tx_active`  out  1  high whenever state != IDLE.

## Operation

**Registers**
- `freq` (32 bits), `phi` (32 bits).
- `g`: gain, unsigned, RAMP_LOG2+1 bits, range 0..2^RAMP_LOG2. Let FULL = 2^RAMP_LOG2.
- `state` ∈ {IDLE, RAMP_UP, ON, RAMP_DOWN}.

**Tuning handshake**
- `freq_ready` = (state == IDLE || state == ON). It is combinational from `state`.
- A transfer occurs on the edge where `freq_valid && freq_ready`; `freq <= freq_data` on that edge.
- While a ramp is in progress `freq_ready` is 0. The source holds its word and the word is accepted after the ramp completes.

**Phase accumulator**
- Each edge: `phi <= phase_clr ? 0 : phi + freq`, with modulo-2^32 wrap.
- `phase_clr` has priority and is honoured in any state.

**Keying FSM** (evaluated each edge)
- IDLE: if `ptt` → RAMP_UP, `g <= 1`. Otherwise `g` stays 0.
- RAMP_UP:
  - If `!ptt` → RAMP_DOWN, `g <= g-1`. If that gives g-1 == 0, go to IDLE instead.
  - Else if g+1 == FULL → ON, `g <= FULL`.
  - Else `g <= g+1`.
- ON: if `!ptt` → RAMP_DOWN, `g <= FULL-1`.
- RAMP_DOWN:
  - If `ptt` → RAMP_UP, `g <= g+1`. If g+1 == FULL, go to ON instead.
  - Else if g-1 == 0 → IDLE, `g <= 0`.
  - Else `g <= g-1`.
- An aborted ramp reverses from the current `g`; `g` never jumps.

**Scaling datapath** (2 stages)
- Stage 1 registers `in_i`, `in_q` and `g`.
- Stage 2 computes `out = (in * $signed({1'b0,g})) >>> RAMP_LOG2`. The shift is arithmetic, i.e. floor rounding.
- Result widths:
  - g == FULL gives out == in exactly.
  - g == 0 gives out == 0.
  - The result always fits in 18 bits, so there is no saturation logic.

**Reset** (asserted asynchronously, low)
- `phi`, `freq`, `g`, `out_i`, `out_q` go to 0.
- `state` goes to IDLE, so `tx_active` = 0 and `freq_ready` = 1.
- Reset mid-ramp or mid-ON drops the output to 0 immediately; there is no ramp-down.

## Timing

- **Phase:** a word accepted on edge k is first added on edge k+1. `phi` is registered with 0-cycle added latency.
- **Ramp duration:** from the edge sampling `ptt`=1 in IDLE to state ON takes FULL edges. From the edge sampling `ptt`=0 in ON to IDLE also takes FULL edges.
- **I/Q latency:** `out_*` reflects `in_*` and `g` sampled 2 edges earlier.
- **tx_active:** rises on the edge that leaves IDLE. It falls on the edge that enters IDLE, which is 2 cycles before the final zero output appears.
- **Simultaneous events:**
  - A handshake on the same edge as ON→RAMP_DOWN is accepted, because `freq_ready` was 1 before the edge.
  - `phase_clr` together with a new word: `phi` clears and `freq` updates on that edge.

## Test plan

1. **Reset and accumulation.** Reset, then `freq_data`=0x10000000 with valid for 1 cycle. Expect `freq_ready`=1 and `phi` = 0, 0x10000000, 0x20000000, …, wrapping to 0 sixteen edges after the first increment.
2. **Full ramp.** RAMP_LOG2=2, `in_i`=1000, `in_q`=-1000, `ptt` held high. Expect `out_i` = 250, 500, 750, 1000 on consecutive cycles starting 2 edges after the first `g` step, state ON after 4 edges, and `out_q` = -250, -500, -750, -1000.
3. **Abort mid-ramp.** RAMP_LOG2=2, `ptt` high for 2 edges then low. Expect `g` to go 1, 2, 1, 0, then IDLE, and `tx_active` to fall on the edge `g` reaches 0.
4. **Handshake stall.** Assert `freq_valid` with 0x1234 during RAMP_UP. Expect `freq_ready`=0 and `freq` unchanged. Expect acceptance on the edge after entering ON, and `phi` stepping by 0x1234 from the following edge.
5. **Phase clear.** With `freq`=5 and `phi`=0x100, pulse `phase_clr`. Expect `phi`=0 on the next edge, then 5, then 10.
6. **Async reset in ON.** Assert `rst` low between edges while `out_i`=1000. Expect `out_i`=0, `tx_active`=0, `phi`=0 immediately and no clock edge required. After release with `ptt` still high, expect a fresh ramp from `g`=1.
